// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between the branch predictor, the resolve queue and the retire stage.
// The slave side is the queue; the master side is the predictor/retire logic.
interface branch_resolve_queue_if;
   logic       pred_valid;
   logic       pred_taken;
   logic [1:0] pred_hist;
   logic       pred_ready;
   logic       res_valid;
   logic       res_taken;
   logic       res_ready;
   logic       upd_valid;
   logic [1:0] upd_hist;
   logic       upd_taken;
   logic       mispredict;

   modport slave (
      input  pred_valid, pred_taken, pred_hist, res_valid, res_taken,
      output pred_ready, res_ready, upd_valid, upd_hist, upd_taken, mispredict
   );

   modport master (
      output pred_valid, pred_taken, pred_hist, res_valid, res_taken,
      input  pred_ready, res_ready, upd_valid, upd_hist, upd_taken, mispredict
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions; checks each against its resolved outcome,
// emits a registered training update, flushes wrong-path entries on mispredict and keeps stats.
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   branch_resolve_queue_if.slave      bus,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_W-1:0]           resolved_cnt,
   output logic [CNT_W-1:0]           miss_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic             r_taken [DEPTH];
   logic [1:0]       r_hist  [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;
   logic             r_upd_valid;
   logic [1:0]       r_upd_hist;
   logic             r_upd_taken;
   logic             r_mispredict;
   logic [CNT_W-1:0] r_res_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   logic             w_pred_ready;
   logic             w_res_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_head_taken;
   logic [1:0]       w_head_hist;
   logic             w_miss;
   logic [PTR_W-1:0] w_wr_next;
   logic [PTR_W-1:0] w_rd_next;
   logic [OCC_W-1:0] w_occ_next;

   assign w_pred_ready = (r_occ != OCC_W'(DEPTH));
   assign w_res_ready  = (r_occ != '0);
   assign w_push       = bus.pred_valid & w_pred_ready;
   assign w_pop        = bus.res_valid & w_res_ready;
   assign w_head_taken = r_taken[r_rd_ptr];
   assign w_head_hist  = r_hist[r_rd_ptr];
   assign w_miss       = w_pop & (w_head_taken != bus.res_taken);

   always_comb begin
      w_wr_next  = r_wr_ptr;
      w_rd_next  = r_rd_ptr;
      w_occ_next = r_occ;
      if (w_push)
         w_wr_next = r_wr_ptr + PTR_W'(1);
      if (w_miss) begin
         // everything younger than the mispredicted branch is wrong-path
         w_rd_next  = w_wr_next;
         w_occ_next = '0;
      end else begin
         if (w_pop)
            w_rd_next = r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + OCC_W'(1);
            2'b01:   w_occ_next = r_occ - OCC_W'(1);
            default: w_occ_next = r_occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_taken[r_wr_ptr] <= bus.pred_taken;
         r_hist[r_wr_ptr]  <= bus.pred_hist;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_occ        <= '0;
         r_upd_valid  <= 1'b0;
         r_upd_hist   <= 2'b00;
         r_upd_taken  <= 1'b0;
         r_mispredict <= 1'b0;
         r_res_cnt    <= '0;
         r_miss_cnt   <= '0;
      end else begin
         r_wr_ptr     <= w_wr_next;
         r_rd_ptr     <= w_rd_next;
         r_occ        <= w_occ_next;
         r_upd_valid  <= w_pop;
         r_mispredict <= w_miss;
         if (w_pop) begin
            r_upd_hist  <= w_head_hist;
            r_upd_taken <= bus.res_taken;
            if (r_res_cnt != {CNT_W{1'b1}})
               r_res_cnt <= r_res_cnt + CNT_W'(1);
         end
         if (w_miss && (r_miss_cnt != {CNT_W{1'b1}}))
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
   end

   assign bus.pred_ready = w_pred_ready;
   assign bus.res_ready  = w_res_ready;
   assign bus.upd_valid  = r_upd_valid;
   assign bus.upd_hist   = r_upd_hist;
   assign bus.upd_taken  = r_upd_taken;
   assign bus.mispredict = r_mispredict;
   assign occupancy      = r_occ;
   assign resolved_cnt   = r_res_cnt;
   assign miss_cnt       = r_miss_cnt;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomised and directed bench for branch_resolve_queue; a queue-based reference model
// predicts state and training updates, a separate monitor checks updates against a scoreboard.
module tb_branch_resolve_queue;
   localparam int DEPTH = 4;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic       taken;
      logic [1:0] hist;
   } ent_t;

   typedef struct packed {
      logic [1:0] hist;
      logic       taken;
      logic       miss;
   } upd_t;

   logic clk;
   logic rst;
   logic [$clog2(DEPTH):0] occupancy;
   logic [CNT_W-1:0]       resolved_cnt;
   logic [CNT_W-1:0]       miss_cnt;

   branch_resolve_queue_if bus ();

   branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .occupancy    (occupancy),
      .resolved_cnt (resolved_cnt),
      .miss_cnt     (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   ent_t mq[$];
   upd_t sb[$];
   int   m_res   = 0;
   int   m_miss  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // training-update monitor: every scoreboard entry is due at the very next negedge
   always @(negedge clk) begin
      upd_t e;
      if (bus.upd_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL upd_unexpected: got upd_valid 1, expected 0 at %0t", $time);
         end else begin
            e = sb.pop_front();
            check("upd_hist", int'(bus.upd_hist), int'(e.hist));
            check("upd_taken", int'(bus.upd_taken), int'(e.taken));
            check("mispredict", int'(bus.mispredict), int'(e.miss));
         end
      end else if (sb.size() != 0) begin
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL upd_missing: got upd_valid 0, expected 1 (hist %0d) at %0t", e.hist, $time);
      end else begin
         check("mispredict_idle", int'(bus.mispredict), 0);
      end
   end

   task automatic check_state();
      check("occupancy", int'(occupancy), mq.size());
      check("pred_ready", int'(bus.pred_ready), (mq.size() != DEPTH) ? 1 : 0);
      check("res_ready", int'(bus.res_ready), (mq.size() != 0) ? 1 : 0);
      check("resolved_cnt", int'(resolved_cnt), m_res);
      check("miss_cnt", int'(miss_cnt), m_miss);
   endtask

   // one clock: drive, advance the model, then check state at the following negedge
   task automatic step(input logic r, input logic pv, input logic pt, input logic [1:0] ph,
                       input logic rv, input logic rt);
      bit   do_push, do_pop, miss;
      ent_t h;
      upd_t u;
      rst            = r;
      bus.pred_valid = pv;
      bus.pred_taken = pt;
      bus.pred_hist  = ph;
      bus.res_valid  = rv;
      bus.res_taken  = rt;
      do_push = pv && (mq.size() != DEPTH);
      do_pop  = rv && (mq.size() != 0);
      if (r) begin
         mq.delete();
         m_res  = 0;
         m_miss = 0;
      end else begin
         miss = 1'b0;
         if (do_pop) begin
            h      = mq.pop_front();
            miss   = (h.taken != rt);
            u.hist = h.hist;
            u.taken = rt;
            u.miss = miss;
            sb.push_back(u);
            if (m_res < CMAX) m_res++;
            if (miss && m_miss < CMAX) m_miss++;
         end
         if (miss) mq.delete();
         else if (do_push) mq.push_back({pt, ph});
      end
      @(posedge clk);
      @(negedge clk);
      check_state();
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic push(input logic pt, input logic [1:0] ph);
      step(1'b0, 1'b1, pt, ph, 1'b0, 1'b0);
   endtask

   task automatic resolve(input logic rt);
      step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, rt);
   endtask

   function automatic logic head_taken();
      return (mq.size() != 0) ? mq[0].taken : 1'b0;
   endfunction

   initial begin
      rst = 1'b1;
      bus.pred_valid = 1'b0;
      bus.pred_taken = 1'b0;
      bus.pred_hist  = 2'b00;
      bus.res_valid  = 1'b0;
      bus.res_taken  = 1'b0;
      @(negedge clk);
      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      check("reset_upd_hist", int'(bus.upd_hist), 0);
      check("reset_upd_taken", int'(bus.upd_taken), 0);

      push(1'b1, 2'b11);
      push(1'b0, 2'b00);
      push(1'b1, 2'b10);
      check("plan_occ3", int'(occupancy), 3);
      resolve(1'b1);
      resolve(1'b0);
      resolve(1'b1);
      idle();
      check("plan_resolved3", int'(resolved_cnt), 3);

      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) push(1'(i & 1), 2'(i));
      check("plan_full_ready", int'(bus.pred_ready), 0);
      step(1'b0, 1'b1, 1'b1, 2'b11, 1'b1, head_taken());
      check("plan_no_passthru", int'(occupancy), 3);

      while (mq.size() != 0) resolve(head_taken());
      push(1'b1, 2'b01);
      push(1'b0, 2'b10);
      push(1'b1, 2'b11);
      step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
      check("plan_flush_occ", int'(occupancy), 0);
      idle();

      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         push(1'b1, 2'b00);
         resolve(1'b0);
      end
      idle();
      check("plan_miss_sat", int'(miss_cnt), CMAX);

      push(1'b0, 2'b01);
      push(1'b1, 2'b10);
      step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
      check("plan_rst_upd", int'(bus.upd_valid), 0);
      idle();

      for (int i = 0; i < 3000; i++) begin
         logic r, pv, pt, rv, rt;
         logic [1:0] ph;
         r  = ($urandom_range(0, 99) == 0);
         pv = ($urandom_range(0, 99) < 60);
         pt = 1'($urandom);
         ph = 2'($urandom);
         rv = ($urandom_range(0, 99) < 50);
         rt = ($urandom_range(0, 99) < 80) ? head_taken() : 1'($urandom);
         step(r, pv, pt, ph, rv, rt);
      end
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
